// File: rtl/cvxif_offload_unit_if.sv
// rtl/cvxif_offload_unit_if.sv - core config, CV-X-IF request/response types and the coprocessor-side interface
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32};
endpackage

package cvxif_pkg;
  localparam int unsigned X_XLEN     = config_pkg::cva6_cfg_empty.XLEN;
  localparam int unsigned X_ID_WIDTH = 3;

  typedef struct packed {
    logic [31:0]                 instr;
    logic [X_ID_WIDTH-1:0]       id;
    logic [1:0][X_XLEN-1:0]      rs;
    logic [1:0]                  rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [X_XLEN-1:0]     data;
    logic                  we;
  } x_result_t;

  typedef struct packed {
    logic         x_compressed_valid;
    logic         x_issue_valid;
    x_issue_req_t x_issue_req;
    logic         x_commit_valid;
    logic         x_result_ready;
    logic         x_mem_ready;
    logic         x_mem_result_valid;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;
endpackage

interface cvxif_offload_unit_if;
  cvxif_pkg::cvxif_req_t  req;
  cvxif_pkg::cvxif_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);
endinterface

// File: rtl/cvxif_offload_unit.sv
// rtl/cvxif_offload_unit.sv - CV-X-IF initiator: issues one offloaded instruction, returns its result or an exception
module cvxif_offload_unit
  import cvxif_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg       = config_pkg::cva6_cfg_empty,
  parameter int unsigned           TransIdWidth  = 3,
  parameter int unsigned           TimeoutCycles = 1024,
  localparam int unsigned          XLEN          = CVA6Cfg.XLEN
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [31:0]             instr_i,
  input  logic [XLEN-1:0]         rs1_i,
  input  logic [XLEN-1:0]         rs2_i,
  input  logic [TransIdWidth-1:0] trans_id_i,
  input  logic                    flush_i,
  output logic                    wb_valid_o,
  input  logic                    wb_ready_i,
  output logic [TransIdWidth-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic                    wb_we_o,
  output logic                    wb_ex_valid_o,
  output logic [XLEN-1:0]         wb_ex_cause_o,
  output logic                    err_stale_o,
  output cvxif_req_t              cvxif_req_o,
  input  cvxif_resp_t             cvxif_resp_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT, RESP} state_e;

  localparam int unsigned          CntW         = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0]      TimeoutLast  = CntW'(TimeoutCycles - 1);
  localparam logic [XLEN-1:0]      CauseIllegal = XLEN'(2);

  state_e                  state_q, state_d;
  logic [X_ID_WIDTH-1:0]   x_id_q, x_id_d, id_q, id_d;
  logic [31:0]             instr_q, instr_d;
  logic [XLEN-1:0]         rs1_q, rs1_d, rs2_q, rs2_d;
  logic [TransIdWidth-1:0] trans_id_q, trans_id_d;
  logic                    flushed_q, flushed_d, wb_allowed_q, wb_allowed_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]         wb_data_q, wb_data_d, wb_cause_q, wb_cause_d;
  logic                    wb_we_q, wb_we_d, wb_ex_q, wb_ex_d;
  logic                    err_stale_q, err_stale_d;
  logic                    issue_hs, res_valid, res_match;

  assign issue_hs  = (state_q == ISSUE) && cvxif_resp_i.x_issue_ready;
  assign res_valid = (state_q == WAIT_RESULT) && cvxif_resp_i.x_result_valid;
  assign res_match = res_valid && (cvxif_resp_i.x_result.id == id_q);

  always_comb begin
    state_d      = state_q;
    x_id_d       = x_id_q;
    id_d         = id_q;
    instr_d      = instr_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    trans_id_d   = trans_id_q;
    flushed_d    = flushed_q;
    wb_allowed_d = wb_allowed_q;
    cnt_d        = cnt_q;
    wb_data_d    = wb_data_q;
    wb_we_d      = wb_we_q;
    wb_ex_d      = wb_ex_q;
    wb_cause_d   = wb_cause_q;
    err_stale_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (instr_valid_i) begin
          instr_d    = instr_i;
          rs1_d      = rs1_i;
          rs2_d      = rs2_i;
          trans_id_d = trans_id_i;
          id_d       = x_id_q;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // Valid must stay up once raised, so a flush is only remembered here.
        flushed_d = flushed_q | flush_i;
        if (issue_hs) begin
          x_id_d       = x_id_q + X_ID_WIDTH'(1);
          wb_allowed_d = cvxif_resp_i.x_issue_resp.writeback;
          if (cvxif_resp_i.x_issue_resp.accept) begin
            state_d = WAIT_RESULT;
          end else begin
            wb_data_d  = '0;
            wb_we_d    = 1'b0;
            wb_ex_d    = 1'b1;
            wb_cause_d = CauseIllegal;
            state_d    = flushed_d ? IDLE : RESP;
          end
        end
      end
      WAIT_RESULT: begin
        flushed_d = flushed_q | flush_i;
        cnt_d     = cnt_q + CntW'(1);
        if (res_match) begin
          wb_data_d  = cvxif_resp_i.x_result.data;
          wb_we_d    = wb_allowed_q & cvxif_resp_i.x_result.we;
          wb_ex_d    = 1'b0;
          wb_cause_d = '0;
          state_d    = flushed_d ? IDLE : RESP;
        end else begin
          err_stale_d = res_valid;
          if (cnt_q == TimeoutLast) begin
            wb_data_d  = '0;
            wb_we_d    = 1'b0;
            wb_ex_d    = 1'b1;
            wb_cause_d = CauseIllegal;
            state_d    = flushed_d ? IDLE : RESP;
          end
        end
      end
      RESP: begin
        if (wb_ready_i || flush_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      flushed_d = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      x_id_q       <= '0;
      id_q         <= '0;
      instr_q      <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      trans_id_q   <= '0;
      flushed_q    <= 1'b0;
      wb_allowed_q <= 1'b0;
      cnt_q        <= '0;
      wb_data_q    <= '0;
      wb_we_q      <= 1'b0;
      wb_ex_q      <= 1'b0;
      wb_cause_q   <= '0;
      err_stale_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_id_q       <= x_id_d;
      id_q         <= id_d;
      instr_q      <= instr_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      trans_id_q   <= trans_id_d;
      flushed_q    <= flushed_d;
      wb_allowed_q <= wb_allowed_d;
      cnt_q        <= cnt_d;
      wb_data_q    <= wb_data_d;
      wb_we_q      <= wb_we_d;
      wb_ex_q      <= wb_ex_d;
      wb_cause_q   <= wb_cause_d;
      err_stale_q  <= err_stale_d;
    end
  end

  assign instr_ready_o = (state_q == IDLE);
  assign wb_valid_o    = (state_q == RESP);
  assign wb_trans_id_o = trans_id_q;
  assign wb_data_o     = wb_data_q;
  assign wb_we_o       = wb_we_q;
  assign wb_ex_valid_o = wb_ex_q;
  assign wb_ex_cause_o = wb_cause_q;
  assign err_stale_o   = err_stale_q;

  always_comb begin
    cvxif_req_o                       = '0;
    cvxif_req_o.x_issue_valid         = (state_q == ISSUE);
    cvxif_req_o.x_issue_req.instr     = instr_q;
    cvxif_req_o.x_issue_req.id        = id_q;
    cvxif_req_o.x_issue_req.rs[0]     = rs1_q;
    cvxif_req_o.x_issue_req.rs[1]     = rs2_q;
    cvxif_req_o.x_issue_req.rs_valid  = {2{state_q == ISSUE}};
    cvxif_req_o.x_result_ready        = (state_q == WAIT_RESULT);
  end

endmodule

// File: tb/tb_cvxif_offload_unit.sv
// tb/tb_cvxif_offload_unit.sv - vector table plus scoreboard bench for cvxif_offload_unit with a scripted coprocessor
module tb_cvxif_offload_unit;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [2:0]  trans_id_i = '0;
  logic        flush_i = 1'b0;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [2:0]  wb_trans_id_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic        wb_ex_valid_o;
  logic [31:0] wb_ex_cause_o;
  logic        err_stale_o;

  cvxif_offload_unit_if ifc ();

  cvxif_offload_unit #(
    .TransIdWidth  (3),
    .TimeoutCycles (8)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr_i),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .trans_id_i    (trans_id_i),
    .flush_i       (flush_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_trans_id_o (wb_trans_id_o),
    .wb_data_o     (wb_data_o),
    .wb_we_o       (wb_we_o),
    .wb_ex_valid_o (wb_ex_valid_o),
    .wb_ex_cause_o (wb_ex_cause_o),
    .err_stale_o   (err_stale_o),
    .cvxif_req_o   (ifc.req),
    .cvxif_resp_i  (ifc.resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  tid;
    int          stall;
    logic        accept;
    logic        wbk;
    int          res_delay;
    logic [31:0] data;
    logic        we;
    logic        stale_first;
    logic        flush;
    int          wb_hold;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_ex;
    logic [31:0] exp_cause;
  } vec_t;

  typedef struct {
    logic [2:0]  tid;
    logic [31:0] data;
    logic        we;
    logic        ex;
    logic [31:0] cause;
  } exp_t;

  vec_t       vecs[11];
  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         stale_cnt = 0;
  logic [2:0] exp_xid = '0;
  logic [2:0] last_id = '0;

  always @(negedge clk) if (err_stale_o) stale_cnt++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_result(input logic [2:0] id, input logic [31:0] data, input logic we);
    ifc.resp.x_result_valid   = 1'b1;
    ifc.resp.x_result.id      = id;
    ifc.resp.x_result.data    = data;
    ifc.resp.x_result.we      = we;
    @(negedge clk);
    ifc.resp.x_result_valid   = 1'b0;
    ifc.resp.x_result         = '0;
  endtask

  task automatic chk_wb(input exp_t e, input string tag);
    chk({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd1);
    chk({tag, "_trans_id"}, 32'(wb_trans_id_o), 32'(e.tid));
    chk({tag, "_data"}, wb_data_o, e.data);
    chk({tag, "_we"}, 32'(wb_we_o), 32'(e.we));
    chk({tag, "_ex"}, 32'(wb_ex_valid_o), 32'(e.ex));
    chk({tag, "_cause"}, wb_ex_cause_o, e.cause);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t       e;
    int         n;
    int         st0;
    logic [2:0] stale_id;
    logic [2:0] cap_id;
    st0      = stale_cnt;
    stale_id = last_id;
    chk("instr_ready_idle", 32'(instr_ready_o), 32'd1);
    instr_valid_i = 1'b1;
    instr_i       = v.instr;
    rs1_i         = v.rs1;
    rs2_i         = v.rs2;
    trans_id_i    = v.tid;
    if (!v.flush) sb.push_back('{tid: v.tid, data: v.exp_data, we: v.exp_we, ex: v.exp_ex, cause: v.exp_cause});
    @(negedge clk);
    // Scramble the core-side inputs so only the latched copy can reach the coprocessor.
    instr_valid_i = 1'b0;
    instr_i       = ~v.instr;
    rs1_i         = ~v.rs1;
    rs2_i         = ~v.rs2;
    trans_id_i    = ~v.tid;
    for (int i = 0; i < v.stall; i++) begin
      chk("stall_issue_valid", 32'(ifc.req.x_issue_valid), 32'd1);
      chk("stall_instr", ifc.req.x_issue_req.instr, v.instr);
      chk("stall_rs1", ifc.req.x_issue_req.rs[0], v.rs1);
      chk("stall_rs2", ifc.req.x_issue_req.rs[1], v.rs2);
      flush_i = v.flush && (i == 0);
      @(negedge clk);
    end
    flush_i = 1'b0;
    chk("issue_valid", 32'(ifc.req.x_issue_valid), 32'd1);
    chk("issue_rs_valid", 32'(ifc.req.x_issue_req.rs_valid), 32'd3);
    chk("issue_id", 32'(ifc.req.x_issue_req.id), 32'(exp_xid));
    cap_id = ifc.req.x_issue_req.id;
    ifc.resp.x_issue_ready          = 1'b1;
    ifc.resp.x_issue_resp.accept    = v.accept;
    ifc.resp.x_issue_resp.writeback = v.wbk;
    @(negedge clk);
    ifc.resp.x_issue_ready = 1'b0;
    ifc.resp.x_issue_resp  = '0;
    last_id = exp_xid;
    exp_xid = exp_xid + 3'd1;
    if (!v.accept) begin
      chk("reject_result_ready", 32'(ifc.req.x_result_ready), 32'd0);
      chk("reject_wb_immediate", 32'(wb_valid_o), 32'd1);
    end else if (v.res_delay < 0) begin
      chk("timeout_result_ready", 32'(ifc.req.x_result_ready), 32'd1);
      n = 0;
      while (!wb_valid_o && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_latency", 32'(n), 32'd8);
    end else begin
      if (v.stale_first) begin
        send_result(stale_id, 32'hBAD0_0BAD, 1'b1);
        repeat (2) @(negedge clk);
      end
      repeat (v.res_delay) @(negedge clk);
      send_result(cap_id, v.data, v.we);
      if (v.flush) begin
        for (int i = 0; i < 4; i++) begin
          chk("flush_no_wb", 32'(wb_valid_o), 32'd0);
          @(negedge clk);
        end
        chk("flush_ready_again", 32'(instr_ready_o), 32'd1);
      end else begin
        chk("result_wb_valid", 32'(wb_valid_o), 32'd1);
      end
    end
    if (!v.flush) begin
      chk("sb_not_empty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int i = 0; i < v.wb_hold; i++) begin
          chk_wb(e, "hold");
          @(negedge clk);
        end
        chk_wb(e, "wb");
        wb_ready_i = 1'b1;
        @(negedge clk);
        wb_ready_i = 1'b0;
        chk("wb_valid_dropped", 32'(wb_valid_o), 32'd0);
        chk("instr_ready_after_wb", 32'(instr_ready_o), 32'd1);
      end
    end
    chk("stale_pulses", 32'(stale_cnt - st0), 32'(v.stale_first));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.resp = '0;
    vecs[0]  = '{32'h0000_300B, 32'h11, 32'h22, 3'd5, 0, 1'b1, 1'b1, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0};
    vecs[1]  = '{32'h0421_00AB, 32'hAAAA_0001, 32'h5555_0002, 3'd1, 4, 1'b1, 1'b1, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 0, 32'h1234_5678, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h3, 32'h4, 3'd2, 0, 1'b0, 1'b1, 0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 32'd2};
    vecs[3]  = '{32'h0000_700B, 32'h7, 32'h8, 3'd3, 1, 1'b1, 1'b1, -1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0, 1'b0, 1'b1, 32'd2};
    vecs[4]  = '{32'h0000_310B, 32'h9, 32'hA, 3'd4, 0, 1'b1, 1'b1, 0, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 0, 32'hCAFE_F00D, 1'b1, 1'b0, 32'd0};
    vecs[5]  = '{32'h0000_320B, 32'hB, 32'hC, 3'd6, 0, 1'b1, 1'b0, 1, 32'h0BAD_C0DE, 1'b1, 1'b0, 1'b0, 0, 32'h0BAD_C0DE, 1'b0, 1'b0, 32'd0};
    vecs[6]  = '{32'h0000_330B, 32'hD, 32'hE, 3'd7, 2, 1'b1, 1'b1, 0, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 0, 32'h0, 1'b0, 1'b0, 32'd0};
    vecs[7]  = '{32'h0000_340B, 32'hF, 32'h10, 3'd0, 0, 1'b1, 1'b1, 2, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 3, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'd0};
    vecs[8]  = '{32'h0000_350B, 32'h11, 32'h12, 3'd1, 1, 1'b1, 1'b1, 0, 32'h0102_0304, 1'b1, 1'b0, 1'b0, 1, 32'h0102_0304, 1'b1, 1'b0, 32'd0};
    vecs[9]  = '{32'h0000_360B, 32'h13, 32'h14, 3'd2, 0, 1'b1, 1'b1, 0, 32'h0506_0708, 1'b1, 1'b0, 1'b0, 0, 32'h0506_0708, 1'b1, 1'b0, 32'd0};
    vecs[10] = '{32'h0000_370B, 32'h15, 32'h16, 3'd3, 0, 1'b1, 1'b1, 1, 32'h090A_0B0C, 1'b0, 1'b0, 1'b0, 0, 32'h090A_0B0C, 1'b0, 1'b0, 32'd0};

    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    chk("rst_instr_ready", 32'(instr_ready_o), 32'd1);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_err_stale", 32'(err_stale_o), 32'd0);
    chk("rst_issue_valid", 32'(ifc.req.x_issue_valid), 32'd0);
    chk("rst_result_ready", 32'(ifc.req.x_result_ready), 32'd0);
    chk("tied_fields", 32'({ifc.req.x_compressed_valid, ifc.req.x_commit_valid,
                            ifc.req.x_mem_ready, ifc.req.x_mem_result_valid}), 32'd0);

    for (int k = 0; k < 11; k++) run_vec(vecs[k]);

    // Abandon an instruction in WAIT_RESULT via reset; its id (3) is stale afterwards.
    instr_valid_i = 1'b1;
    instr_i       = 32'h0000_380B;
    trans_id_i    = 3'd4;
    @(negedge clk);
    instr_valid_i                   = 1'b0;
    ifc.resp.x_issue_ready          = 1'b1;
    ifc.resp.x_issue_resp.accept    = 1'b1;
    ifc.resp.x_issue_resp.writeback = 1'b1;
    @(negedge clk);
    ifc.resp.x_issue_ready = 1'b0;
    ifc.resp.x_issue_resp  = '0;
    chk("pre_rst_wait", 32'(ifc.req.x_result_ready), 32'd1);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid_rst_instr_ready", 32'(instr_ready_o), 32'd1);
    chk("mid_rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("mid_rst_err_stale", 32'(err_stale_o), 32'd0);
    chk("mid_rst_issue_valid", 32'(ifc.req.x_issue_valid), 32'd0);
    chk("mid_rst_result_ready", 32'(ifc.req.x_result_ready), 32'd0);
    rst_ni  = 1'b1;
    last_id = exp_xid;
    exp_xid = '0;
    @(negedge clk);
    run_vec('{32'h0000_390B, 32'h17, 32'h18, 3'd6, 0, 1'b1, 1'b1, 0, 32'h7777_8888, 1'b1, 1'b1, 1'b0, 0, 32'h7777_8888, 1'b1, 1'b0, 32'd0});

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cvxif_offload_unit.md
Name: cvxif_offload_unit

Overview:
- Core-side CV-X-IF initiator. Takes one offloaded instruction at a time from the CVA6 issue stage and drives the issue request on cvxif_req_o. Collects the coprocessor result from cvxif_resp_i and returns it to writeback with the core transaction ID.
- Reports rejected instructions as illegal-instruction exceptions.
- Guards against a stuck coprocessor with a timeout counter.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, core config; XLEN taken from CVA6Cfg.XLEN.
- TransIdWidth, 3, width of the core scoreboard transaction ID.
- TimeoutCycles, 1024, number of cycles in WAIT_RESULT before the timeout fires; minimum 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- instr_valid_i  in  1  offload request from issue stage
- instr_ready_o  out  1  unit can accept a request
- instr_i  in  32  instruction word
- rs1_i, rs2_i  in  XLEN  operand values
- trans_id_i  in  TransIdWidth  core transaction ID
- flush_i  in  1  squash the in-flight instruction
- wb_valid_o  out  1  result/exception valid
- wb_ready_i  in  1  writeback accepts
- wb_trans_id_o  out  TransIdWidth  returned transaction ID
- wb_data_o  out  XLEN  result data
- wb_we_o  out  1  rd write enable
- wb_ex_valid_o  out  1  exception flag
- wb_ex_cause_o  out  XLEN  exception cause
- err_stale_o  out  1  one-cycle pulse: stale result dropped
- cvxif_req_o  out  cvxif_req_t  to coprocessor
- cvxif_resp_i  in  cvxif_resp_t  from coprocessor

Behaviour:
- Reset (rst_ni low at a clock edge):
  - state is IDLE; x_id counter is 0; timeout counter is 0.
  - wb_valid_o, err_stale_o, x_issue_valid and x_result_ready are 0.
  - Reset mid-operation abandons the instruction silently; a result arriving after reset is treated as stale.
- Unused request fields are tied to 0:
  - x_compressed_valid, x_commit_valid, x_mem_ready, x_mem_result_valid.
  - x_issue_req.rs_valid = 2'b11 whenever issue is valid.
- FSM states: IDLE, ISSUE, WAIT_RESULT, RESP.
- IDLE:
  - instr_ready_o = 1.
  - When instr_valid_i is high: latch instr, rs1, rs2, trans_id and x_id; go to ISSUE.
- ISSUE:
  - x_issue_valid = 1; instr/rs/id are held stable from the latched copy until the handshake.
  - Handshake = x_issue_valid & x_issue_ready, with accept and writeback sampled in the same cycle.
  - On handshake, x_id increments modulo 2^X_ID_WIDTH.
  - accept = 1: go to WAIT_RESULT.
  - accept = 0: load the RESP register with wb_ex_valid_o = 1, cause = 2 (illegal instruction), data = 0, we = 0; go to RESP.
  - flush_i in ISSUE does not drop x_issue_valid (protocol requires valid to be held); it sets a sticky flushed_q flag instead.
- WAIT_RESULT:
  - x_result_ready = 1; timeout counter increments each cycle.
  - Result with x_result_valid and id == latched x_id:
    - load RESP with data, we = latched writeback & result.we, and exception = 0.
    - if flushed_q: go to IDLE with no writeback; otherwise go to RESP.
    - The result may arrive the first cycle after the handshake.
  - Result with id != latched x_id: consume it, pulse err_stale_o, stay in WAIT_RESULT.
  - flush_i sets flushed_q.
  - Timeout when the counter reaches TimeoutCycles-1 with no matching result:
    - load RESP with exception, cause = 2, we = 0, and go to RESP; if flushed_q, go to IDLE instead.
    - A later result is then stale.
- RESP:
  - wb_valid_o = 1, wb_trans_id_o = latched trans_id.
  - Outputs are held until wb_ready_i; on that cycle go to IDLE.
  - flush_i in RESP: drop wb_valid_o next cycle and go to IDLE.
- flushed_q and the timeout counter clear on entering IDLE.
- In IDLE with instr_valid_i, the instruction is accepted, so a new instruction can start the cycle after a RESP handshake. Throughput is one instruction per at least 3 cycles.
- x_result_ready = 0 outside WAIT_RESULT; results arriving then are not consumed. The coprocessor must not send unsolicited results; any such result is consumed as stale on the next WAIT_RESULT entry.

Test Plan:
- Accepted MV_V_X-type instr, trans_id = 5, coprocessor returns data 0xDEAD_BEEF, we = 1, one cycle after accept -> wb_valid_o with trans_id 5, data 0xDEADBEEF, wb_we_o = 1, ex = 0; instr_ready_o back to 1 the cycle after wb_ready_i.
- x_issue_ready held low for 4 cycles -> x_issue_valid stays 1 with constant instr/rs/id; handshake on cycle 5; x_id increments by 1.
- accept = 0 -> wb_ex_valid_o = 1, cause = 2, wb_we_o = 0; no result expected; x_result_ready stays 0.
- Result with a wrong id, then the correct id 3 cycles later -> one err_stale_o pulse, then the normal writeback of the correct data.
- No result, TimeoutCycles = 8 -> exception cause 2 exactly 8 cycles after entering WAIT_RESULT; a late result in the next instruction's WAIT_RESULT -> err_stale_o.
- flush_i during ISSUE, then the result arrives -> the result is consumed and wb_valid_o never asserts; a new instr_valid_i is accepted afterwards.
- wb_ready_i held low for 3 cycles -> all wb_* outputs stable throughout.
- x_id wraps from 2^X_ID_WIDTH-1 to 0 and results are still matched correctly.
- rst_ni low during WAIT_RESULT -> all outputs at reset values on the next cycle.
